// File: rtl/bj_rom_pkg.sv
// Shared types and the fixed ROM region map for the Bomb Jack download sequencer.
package bj_rom_pkg;

    localparam int unsigned NUM_REGIONS = 6;

    typedef enum logic [2:0] {
        RegMain    = 3'd0,
        RegSound   = 3'd1,
        RegChars   = 3'd2,
        RegTiles   = 3'd3,
        RegSprites = 3'd4,
        RegBgProm  = 3'd5
    } region_e;

    localparam logic [16:0] REGION_BASE [NUM_REGIONS] = '{
        17'h00000, 17'h0E000, 17'h10000, 17'h13000, 17'h19000, 17'h1F000
    };

    localparam logic [15:0] REGION_SIZE [NUM_REGIONS] = '{
        16'hE000, 16'h2000, 16'h3000, 16'h6000, 16'h6000, 16'h1000
    };

    typedef enum logic [1:0] {
        StReady = 2'd0,
        StLoad  = 2'd1,
        StFlush = 2'd2,
        StHold  = 2'd3
    } state_e;

endpackage

// File: rtl/bj_rom_region_dec.sv
// Combinational decode of a download byte address into a ROM region and local offset.
module bj_rom_region_dec
    import bj_rom_pkg::*;
(
    input  logic [24:0]            dn_addr,
    output logic [NUM_REGIONS-1:0] region_hot,
    output logic [15:0]            local_addr,
    output logic                   out_of_range
);

    always_comb begin
        region_hot   = '0;
        local_addr   = '0;
        out_of_range = |dn_addr[24:17];
        // Compare the offset against the size so the last region needs no 18-bit end address.
        for (int i = 0; i < NUM_REGIONS; i++) begin
            if (!out_of_range && dn_addr[16:0] >= REGION_BASE[i] &&
                (dn_addr[16:0] - REGION_BASE[i]) < {1'b0, REGION_SIZE[i]}) begin
                region_hot[i] = 1'b1;
                local_addr    = 16'(dn_addr[16:0] - REGION_BASE[i]);
            end
        end
    end

endmodule

// File: rtl/bj_rom_loader.sv
// ROM download sequencer: routes ioctl bytes to region stores, holds the core in reset
// across the load, and reports completion, checksum and a sticky error.
module bj_rom_loader
    import bj_rom_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES = 1024,
    parameter int unsigned CKSUM_W     = 16
) (
    input  logic                   clk_sys,
    input  logic                   reset_n,
    input  logic                   dn_download,
    input  logic                   dn_wr,
    input  logic [24:0]            dn_addr,
    input  logic [7:0]             dn_data,
    output logic [NUM_REGIONS-1:0] rom_we,
    output logic [15:0]            rom_addr,
    output logic [7:0]             rom_data,
    output logic                   core_reset_n,
    output logic                   dl_done,
    output logic                   dl_error,
    output logic [CKSUM_W-1:0]     dl_cksum
);

    localparam int unsigned HoldW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HoldW-1:0] HoldLast = HoldW'(HOLD_CYCLES - 1);

    state_e                 state;
    logic [HoldW-1:0]       hold_cnt;
    logic [15:0]            byte_cnt [NUM_REGIONS];
    logic [NUM_REGIONS-1:0] region_hot;
    logic [15:0]            local_addr;
    logic                   out_of_range;
    logic                   count_bad;
    logic                   sat_hit;

    bj_rom_region_dec u_dec (
        .dn_addr      (dn_addr),
        .region_hot   (region_hot),
        .local_addr   (local_addr),
        .out_of_range (out_of_range)
    );

    always_comb begin
        count_bad = 1'b0;
        sat_hit   = 1'b0;
        for (int i = 0; i < NUM_REGIONS; i++) begin
            if (byte_cnt[i] != REGION_SIZE[i]) count_bad = 1'b1;
            if (region_hot[i] && byte_cnt[i] == 16'hFFFF) sat_hit = 1'b1;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            state        <= StHold;
            hold_cnt     <= '0;
            rom_we       <= '0;
            rom_addr     <= '0;
            rom_data     <= '0;
            core_reset_n <= 1'b0;
            dl_done      <= 1'b0;
            dl_error     <= 1'b0;
            dl_cksum     <= '0;
            for (int i = 0; i < NUM_REGIONS; i++) byte_cnt[i] <= '0;
        end else begin
            rom_we <= '0;
            if (state == StLoad) begin
                // A strobe coincident with the falling download edge is still taken.
                if (dn_wr) begin
                    if (out_of_range || sat_hit) dl_error <= 1'b1;
                    if (!out_of_range) begin
                        rom_we   <= region_hot;
                        rom_addr <= local_addr;
                        rom_data <= dn_data;
                        dl_cksum <= dl_cksum + CKSUM_W'(dn_data);
                        for (int i = 0; i < NUM_REGIONS; i++) begin
                            if (region_hot[i] && byte_cnt[i] != 16'hFFFF) begin
                                byte_cnt[i] <= byte_cnt[i] + 16'd1;
                            end
                        end
                    end
                end
                if (!dn_download) state <= StFlush;
            end else if (dn_download) begin
                state        <= StLoad;
                core_reset_n <= 1'b0;
                dl_done      <= 1'b0;
                dl_error     <= 1'b0;
                dl_cksum     <= '0;
                for (int i = 0; i < NUM_REGIONS; i++) byte_cnt[i] <= '0;
            end else begin
                case (state)
                    StFlush: begin
                        if (count_bad) dl_error <= 1'b1;
                        hold_cnt <= '0;
                        state    <= StHold;
                    end
                    StHold: begin
                        if (hold_cnt == HoldLast) begin
                            state        <= StReady;
                            core_reset_n <= 1'b1;
                            dl_done      <= 1'b1;
                        end else begin
                            hold_cnt <= hold_cnt + 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
